mmio_sw_led_timer: RTL and testbench

MMIO_SW_LED_TIMER -- requirements
Module: mmio_sw_led_timer

---
 rtl/mmio_sw_led_timer.sv | 160 ++++++++++++++++
 tb/tb_mmio_sw_led_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_sw_led_timer.sv
// Memory-mapped switch/LED/timer peripheral: three 16-bit registers at BASE_ADDR,
// with a two-flop switch synchronizer and a whole-vector debouncer.
module mmio_sw_led_timer #(
    parameter logic [15:0] BASE_ADDR       = 16'h2000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] memAddr,
    input  logic        re_L,
    input  logic        we_L,
    input  logic [15:0] wrData,
    output logic [15:0] rdData,
    output logic        rdEn_L,
    input  logic [15:0] SW,
    output logic [15:0] LEDR
);

    localparam logic [15:0] ADDR_SWLED = BASE_ADDR;
    localparam logic [15:0] ADDR_TIMER = BASE_ADDR + 16'd2;
    localparam logic [15:0] ADDR_STAT  = BASE_ADDR + 16'd4;
    localparam logic [7:0]  CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);

    logic        hit_swled;
    logic        hit_timer;
    logic        hit_stat;
    logic        hit_any;
    logic        rd_en;
    logic        stat_rd;
    logic        wr_swled;
    logic        wr_timer;
    logic        wr_stat;

    logic [15:0] led_q,       led_d;
    logic [15:0] timer_q,     timer_d;
    logic        timer_en_q,  timer_en_d;
    logic [15:0] sync1_q;
    logic [15:0] sync2_q;
    logic [15:0] cand_q,      cand_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic [15:0] sw_stable_q, sw_stable_d;
    logic        sw_chg_q,    sw_chg_d;
    logic        wrap_q,      wrap_d;
    logic        wrap_set;
    logic        sw_chg_set;

    // Full 16-bit compare: odd addresses and aliases never hit.
    always_comb begin
        hit_swled = (memAddr == ADDR_SWLED);
        hit_timer = (memAddr == ADDR_TIMER);
        hit_stat  = (memAddr == ADDR_STAT);
        hit_any   = hit_swled | hit_timer | hit_stat;
        rd_en     = ~re_L & we_L & hit_any;
        stat_rd   = rd_en & hit_stat;
        wr_swled  = ~we_L & hit_swled;
        wr_timer  = ~we_L & hit_timer;
        wr_stat   = ~we_L & hit_stat;
    end

    assign rdEn_L = ~rd_en;

    always_comb begin
        rdData = 16'h0000;
        if (rd_en) begin
            if (hit_swled) begin
                rdData = sw_stable_q;
            end else if (hit_timer) begin
                rdData = timer_q;
            end else begin
                rdData = {13'b0, timer_en_q, wrap_q, sw_chg_q};
            end
        end
    end

    always_comb begin
        led_d      = led_q;
        timer_en_d = timer_en_q;
        if (wr_swled) begin
            led_d = wrData;
        end
        if (wr_stat) begin
            timer_en_d = wrData[0];
        end
    end

    // A TIMER write overrides the increment, so a write landing on 16'hFFFF never wraps.
    always_comb begin
        timer_d  = timer_q;
        wrap_set = 1'b0;
        if (wr_timer) begin
            timer_d = wrData;
        end else if (timer_en_q) begin
            timer_d  = timer_q + 16'd1;
            wrap_set = (timer_q == 16'hFFFF);
        end
    end

    // Whole-vector debounce; cnt saturates at CNT_LAST and keeps reloading swStable.
    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        sw_stable_d = sw_stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
            sw_stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Sticky flags cleared by a STAT read; a set on the same edge wins.
    always_comb begin
        sw_chg_set = (sw_stable_d != sw_stable_q);
        sw_chg_d   = sw_chg_set | (sw_chg_q & ~stat_rd);
        wrap_d     = wrap_set | (wrap_q & ~stat_rd);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 16'h0000;
            sync2_q <= 16'h0000;
        end else begin
            sync1_q <= SW;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand_q      <= 16'h0000;
            cnt_q       <= 8'd0;
            sw_stable_q <= 16'h0000;
            sw_chg_q    <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            sw_stable_q <= sw_stable_d;
            sw_chg_q    <= sw_chg_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q      <= 16'h0000;
            timer_q    <= 16'h0000;
            timer_en_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            led_q      <= led_d;
            timer_q    <= timer_d;
            timer_en_q <= timer_en_d;
            wrap_q     <= wrap_d;
        end
    end

    assign LEDR = led_q;

endmodule

// File: tb/tb_mmio_sw_led_timer.sv
// Bench for mmio_sw_led_timer: register access table plus timer, debounce and reset sequences.
module tb_mmio_sw_led_timer;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] memAddr;
    logic        re_L;
    logic        we_L;
    logic [15:0] wrData;
    logic [15:0] rdData;
    logic        rdEn_L;
    logic [15:0] SW;
    logic [15:0] LEDR;

    always #5 clock = ~clock;

    mmio_sw_led_timer #(
        .BASE_ADDR       (16'h2000),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .memAddr (memAddr),
        .re_L    (re_L),
        .we_L    (we_L),
        .wrData  (wrData),
        .rdData  (rdData),
        .rdEn_L  (rdEn_L),
        .SW      (SW),
        .LEDR    (LEDR)
    );

    // sig: 0 = rdData, 1 = rdEn_L, 2 = LEDR
    typedef struct {
        int          sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic        re;
        logic        we;
        logic [15:0] wd;
        logic        exp_en;
        logic [15:0] exp_rd;
        logic [15:0] exp_led;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vt[17];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic [15:0] a, input logic r, input logic w,
                                input logic [15:0] d, input logic en,
                                input logic [15:0] rd, input logic [15:0] led,
                                input string nm);
        vec_t v;
        v.addr = a; v.re = r; v.we = w; v.wd = d;
        v.exp_en = en; v.exp_rd = rd; v.exp_led = led; v.name = nm;
        return v;
    endfunction

    function automatic void push(input int sig, input logic [15:0] v, input string nm);
        exp_t e;
        e.sig = sig; e.val = v; e.name = nm;
        sb.push_back(e);
    endfunction

    task automatic check_sb();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.sig)
                0:       act = rdData;
                1:       act = {15'b0, rdEn_L};
                default: act = LEDR;
            endcase
            n_total++;
            if (act === e.val) n_pass++;
            else $display("FAIL %s: got %h want %h", e.name, act, e.val);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d);
        memAddr = a; re_L = r; we_L = w; wrData = d;
    endtask

    // Drive one bus cycle, compare pending expectations mid-cycle, then pass the edge.
    task automatic cyc(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d);
        drive(a, r, w, d);
        @(negedge clock);
        check_sb();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        SW    = 16'h0000;
        drive(16'h2000, 1'b0, 1'b1, 16'h0000);
        #2;
        push(1, 16'h0000, "rst_rden");
        push(0, 16'h0000, "rst_rddata");
        push(2, 16'h0000, "rst_ledr");
        check_sb();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        vt[0]  = mk(16'h2000, 1, 0, 16'hA5A5, 1, 16'h0000, 16'h0000, "wr_swled");
        vt[1]  = mk(16'h2000, 0, 1, 16'h0000, 0, 16'h0000, 16'hA5A5, "rd_swled");
        vt[2]  = mk(16'h2004, 0, 1, 16'h0000, 0, 16'h0000, 16'hA5A5, "rd_stat");
        vt[3]  = mk(16'h2002, 0, 1, 16'h0000, 0, 16'h0000, 16'hA5A5, "rd_timer");
        vt[4]  = mk(16'h2001, 1, 0, 16'h1235, 1, 16'h0000, 16'hA5A5, "wr_2001");
        vt[5]  = mk(16'h2006, 1, 0, 16'hFFFF, 1, 16'h0000, 16'hA5A5, "wr_2006");
        vt[6]  = mk(16'h2001, 0, 1, 16'h0000, 1, 16'h0000, 16'hA5A5, "rd_2001");
        vt[7]  = mk(16'h2006, 0, 1, 16'h0000, 1, 16'h0000, 16'hA5A5, "rd_2006");
        vt[8]  = mk(16'h2002, 0, 1, 16'h0000, 0, 16'h0000, 16'hA5A5, "rd_timer_unchg");
        vt[9]  = mk(16'h2004, 0, 1, 16'h0000, 0, 16'h0000, 16'hA5A5, "rd_stat_unchg");
        vt[10] = mk(16'h2000, 0, 0, 16'h5A5A, 1, 16'h0000, 16'hA5A5, "rd_wr_both");
        vt[11] = mk(16'h2000, 1, 1, 16'h0000, 1, 16'h0000, 16'h5A5A, "idle");
        vt[12] = mk(16'h3000, 0, 1, 16'h0000, 1, 16'h0000, 16'h5A5A, "rd_3000");
        vt[13] = mk(16'h2002, 1, 0, 16'h0010, 1, 16'h0000, 16'h5A5A, "wr_timer");
        vt[14] = mk(16'h2002, 0, 1, 16'h0000, 0, 16'h0010, 16'h5A5A, "rd_timer_hold");
        vt[15] = mk(16'h2002, 0, 1, 16'h0000, 0, 16'h0010, 16'h5A5A, "rd_timer_hold2");
        vt[16] = mk(16'h2000, 0, 1, 16'h0000, 0, 16'h0000, 16'h5A5A, "rd_swled_zero");

        for (int i = 0; i < 17; i++) begin
            push(1, {15'b0, vt[i].exp_en}, {vt[i].name, "_rden"});
            push(0, vt[i].exp_rd, {vt[i].name, "_rddata"});
            push(2, vt[i].exp_led, {vt[i].name, "_ledr"});
            cyc(vt[i].addr, vt[i].re, vt[i].we, vt[i].wd);
        end

        // Timer enable and wrap
        cyc(16'h2002, 1, 0, 16'hFFFE);
        cyc(16'h2004, 1, 0, 16'h0001);
        push(0, 16'hFFFE, "tmr_fffe");      cyc(16'h2002, 0, 1, 16'h0000);
        push(0, 16'hFFFF, "tmr_ffff");      cyc(16'h2002, 0, 1, 16'h0000);
        push(0, 16'h0000, "tmr_wrap0");     cyc(16'h2002, 0, 1, 16'h0000);
        push(0, 16'h0006, "stat_wrap");     cyc(16'h2004, 0, 1, 16'h0000);
        push(0, 16'h0004, "stat_cleared");  cyc(16'h2004, 0, 1, 16'h0000);

        // STAT read held across the wrapping edge
        cyc(16'h2002, 1, 0, 16'hFFFE);
        push(0, 16'h0004, "stat_pre_wrap");  cyc(16'h2004, 0, 1, 16'h0000);
        push(0, 16'h0004, "stat_at_wrap");   cyc(16'h2004, 0, 1, 16'h0000);
        push(0, 16'h0006, "stat_wrap_kept"); cyc(16'h2004, 0, 1, 16'h0000);
        push(0, 16'h0004, "stat_clr2");      cyc(16'h2004, 0, 1, 16'h0000);

        // TIMER write on the edge where the timer sits at FFFF
        cyc(16'h2002, 1, 0, 16'hFFFE);
        cyc(16'h2000, 1, 1, 16'h0000);
        cyc(16'h2002, 1, 0, 16'h0100);
        push(0, 16'h0100, "tmr_wr_prio");   cyc(16'h2002, 0, 1, 16'h0000);
        push(0, 16'h0004, "no_wrap_on_wr"); cyc(16'h2004, 0, 1, 16'h0000);
        cyc(16'h2004, 1, 0, 16'h0000);
        push(0, 16'h0000, "stat_off");      cyc(16'h2004, 0, 1, 16'h0000);
        push(0, 16'h0103, "tmr_frozen");    cyc(16'h2002, 0, 1, 16'h0000);
        push(0, 16'h0103, "tmr_frozen2");   cyc(16'h2002, 0, 1, 16'h0000);

        // Five-cycle glitch must be rejected
        SW = 16'h0001;
        repeat (5) cyc(16'h2000, 1, 1, 16'h0000);
        SW = 16'h0000;
        for (int k = 0; k < 30; k++) begin
            push(0, 16'h0000, "glitch_swled");
            cyc(16'h2000, 0, 1, 16'h0000);
        end
        push(0, 16'h0000, "glitch_no_chg"); cyc(16'h2004, 0, 1, 16'h0000);

        // Clean change visible exactly DEBOUNCE_CYCLES+3 edges after first sampling edge
        SW = 16'h00FF;
        cyc(16'h2000, 1, 1, 16'h0000);
        for (int k = 1; k <= 19; k++) begin
            push(0, (k >= 19) ? 16'h00FF : 16'h0000, $sformatf("deb_edge%0d", k));
            cyc(16'h2000, 0, 1, 16'h0000);
        end
        push(0, 16'h0001, "stat_chg");     cyc(16'h2004, 0, 1, 16'h0000);
        push(0, 16'h0000, "stat_chg_clr"); cyc(16'h2004, 0, 1, 16'h0000);

        // Asynchronous reset while the timer runs
        cyc(16'h2000, 1, 0, 16'hFFFF);
        cyc(16'h2004, 1, 0, 16'h0001);
        cyc(16'h2002, 1, 0, 16'h1234);
        drive(16'h2002, 1'b0, 1'b1, 16'h0000);
        #1;
        push(0, 16'h1234, "pre_rst_tmr");
        push(2, 16'hFFFF, "pre_rst_ledr");
        check_sb();
        #1;
        reset = 1'b1;
        #1;
        push(0, 16'h0000, "async_rst_tmr");
        push(2, 16'h0000, "async_rst_ledr");
        push(1, 16'h0000, "async_rst_rden");
        check_sb();
        drive(16'h2000, 1'b0, 1'b1, 16'h0000);
        #1;
        push(0, 16'h0000, "async_rst_swled");
        check_sb();
        drive(16'h2004, 1'b0, 1'b1, 16'h0000);
        #1;
        push(0, 16'h0000, "async_rst_stat");
        check_sb();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int k = 1; k <= 19; k++) begin
            push(0, (k >= 19) ? 16'h00FF : 16'h0000, $sformatf("post_rst_deb%0d", k));
            cyc(16'h2000, 0, 1, 16'h0000);
        end
        push(0, 16'h0001, "post_rst_stat"); cyc(16'h2004, 0, 1, 16'h0000);
        push(0, 16'h0000, "post_rst_tmr");  cyc(16'h2002, 0, 1, 16'h0000);
        push(2, 16'h0000, "post_rst_ledr"); cyc(16'h2000, 1, 1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
